// File: rtl/usbh_crc_pkg.sv
// Shared types and constants for the USB host CRC engine: mode/state enums,
// reflected polynomials, init and residue values, and output formatting helpers.
package usbh_crc_pkg;

   typedef enum logic {
      CRC_MODE5  = 1'b0,
      CRC_MODE16 = 1'b1
   } crc_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } crc_state_e;

   localparam logic [4:0]  CRC5_POLY     = 5'h14;
   localparam logic [4:0]  CRC5_INIT     = 5'h1F;
   localparam logic [4:0]  CRC5_RESIDUE  = 5'h06;
   localparam logic [15:0] CRC16_POLY    = 16'hA001;
   localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUE = 16'hB001;

   // All-ones covers both modes; CRC5 only looks at the low five bits.
   localparam logic [15:0] CRC_REG_INIT  = {11'h7FF, CRC5_INIT} & CRC16_INIT;

   // Wire-order CRC as transmitted: complement of the raw register, CRC5 zero-extended.
   function automatic logic [15:0] crc_wire_fmt(input crc_mode_e mode, input logic [15:0] r);
      logic [15:0] f;
      case (mode)
         CRC_MODE16: f = ~r;
         CRC_MODE5:  f = {11'h000, ~r[4:0]};
         default:    f = 16'h0000;
      endcase
      return f;
   endfunction

   // Checker mode: after data plus received CRC, a clean packet leaves the fixed residue.
   function automatic logic crc_residue_match(input crc_mode_e mode, input logic [15:0] r);
      logic m;
      case (mode)
         CRC_MODE16: m = (r == CRC16_RESIDUE);
         CRC_MODE5:  m = (r[4:0] == CRC5_RESIDUE);
         default:    m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/usbh_crc_step.sv
// Combinational one-beat CRC update: unrolls DATA_W reflected shift steps,
// applying only the first nbits bits (bit0 first on the wire).
module usbh_crc_step
   import usbh_crc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NB_W   = $clog2(DATA_W + 1)
) (
   input  crc_mode_e         mode,
   input  logic [15:0]       crc_in,
   input  logic [DATA_W-1:0] data,
   input  logic [NB_W-1:0]   nbits,
   output logic [15:0]       crc_out
);

   logic [4:0]  r5_s;
   logic [15:0] r16_s;

   // Serial LFSR unrolled across the beat; bits at or beyond nbits leave the register untouched.
   always_comb begin
      r5_s  = crc_in[4:0];
      r16_s = crc_in;
      for (int i = 0; i < DATA_W; i++) begin
         r5_s  = (i < int'(nbits))
               ? ({1'b0, r5_s[4:1]} ^ (((r5_s[0] ^ data[i]) == 1'b1) ? CRC5_POLY : 5'h00))
               : r5_s;
         r16_s = (i < int'(nbits))
               ? ({1'b0, r16_s[15:1]} ^ (((r16_s[0] ^ data[i]) == 1'b1) ? CRC16_POLY : 16'h0000))
               : r16_s;
      end
      if (mode == CRC_MODE16) begin
         crc_out = r16_s;
      end else begin
         crc_out = {11'h000, r5_s};
      end
   end

endmodule

// File: rtl/usbh_crc_engine.sv
// USB host CRC5/CRC16 generator/checker: streams variable-width beats LSB first,
// pulses crc_valid_o with the wire-order CRC and residue check one cycle after the last beat.
module usbh_crc_engine
   import usbh_crc_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int CNT_W  = 16,
   localparam int NB_W   = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic              abort_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [NB_W-1:0]   nbits_i,
   input  logic              last_i,
   output logic              busy_o,
   output logic              crc_valid_o,
   output logic [15:0]       crc_o,
   output logic              residue_ok_o,
   output logic [CNT_W-1:0]  bit_cnt_o
);

   crc_state_e       state_r;
   crc_state_e       state_s;
   crc_mode_e        mode_r;
   crc_mode_e        step_mode_s;
   logic [15:0]      crc_r;
   logic [15:0]      step_crc_s;
   logic [15:0]      step_next_s;
   logic [15:0]      crc_out_r;
   logic             res_ok_r;
   logic             crc_valid_r;
   logic [CNT_W-1:0] bit_cnt_r;
   logic [CNT_W-1:0] bit_base_s;
   logic [CNT_W:0]   cnt_sum_s;
   logic [CNT_W-1:0] cnt_next_s;
   logic             ready_s;
   logic             accept_s;

   // Beat acceptance and step operands; a start cycle computes from the init value and new mode.
   always_comb begin
      ready_s     = (state_r == ST_RUN) | start_i;
      accept_s    = valid_i & ready_s;
      step_mode_s = (start_i == 1'b1) ? crc_mode_e'(mode_i) : mode_r;
      step_crc_s  = (start_i == 1'b1) ? CRC_REG_INIT : crc_r;
      bit_base_s  = (start_i == 1'b1) ? {CNT_W{1'b0}} : bit_cnt_r;
      cnt_sum_s   = {1'b0, bit_base_s} + {{(CNT_W + 1 - NB_W){1'b0}}, nbits_i};
      if (cnt_sum_s[CNT_W] == 1'b1) begin
         cnt_next_s = {CNT_W{1'b1}};
      end else begin
         cnt_next_s = cnt_sum_s[CNT_W-1:0];
      end
   end

   usbh_crc_step #(
      .DATA_W (DATA_W),
      .NB_W   (NB_W)
   ) u_step (
      .mode    (step_mode_s),
      .crc_in  (step_crc_s),
      .data    (data_i),
      .nbits   (nbits_i),
      .crc_out (step_next_s)
   );

   // Next-state logic: abort beats start, start beats the current state.
   always_comb begin
      state_s = state_r;
      if (abort_i == 1'b1) begin
         state_s = ST_IDLE;
      end else if (start_i == 1'b1) begin
         state_s = ((valid_i & last_i) == 1'b1) ? ST_DONE : ST_RUN;
      end else begin
         case (state_r)
            ST_IDLE: state_s = ST_IDLE;
            ST_RUN:  state_s = ((accept_s & last_i) == 1'b1) ? ST_DONE : ST_RUN;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // CRC register, latched mode and saturating bit counter.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         crc_r     <= CRC_REG_INIT;
         mode_r    <= CRC_MODE5;
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (abort_i) begin
         crc_r     <= CRC_REG_INIT;
         bit_cnt_r <= {CNT_W{1'b0}};
      end else if (start_i | accept_s) begin
         mode_r    <= step_mode_s;
         crc_r     <= (accept_s == 1'b1) ? step_next_s : step_crc_s;
         bit_cnt_r <= (accept_s == 1'b1) ? cnt_next_s : bit_base_s;
      end else begin
         crc_r     <= crc_r;
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // Result registers load on entry to DONE and hold until the next start or abort.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         crc_valid_r <= 1'b0;
         crc_out_r   <= 16'h0000;
         res_ok_r    <= 1'b0;
      end else begin
         crc_valid_r <= (state_s == ST_DONE);
         if (abort_i) begin
            crc_out_r <= 16'h0000;
            res_ok_r  <= 1'b0;
         end else if (state_s == ST_DONE) begin
            crc_out_r <= crc_wire_fmt(step_mode_s, step_next_s);
            res_ok_r  <= crc_residue_match(step_mode_s, step_next_s);
         end else if (start_i) begin
            crc_out_r <= 16'h0000;
            res_ok_r  <= 1'b0;
         end else begin
            crc_out_r <= crc_out_r;
            res_ok_r  <= res_ok_r;
         end
      end
   end

   assign ready_o      = ready_s;
   assign busy_o       = (state_r == ST_RUN);
   assign crc_valid_o  = crc_valid_r;
   assign crc_o        = crc_out_r;
   assign residue_ok_o = res_ok_r;
   assign bit_cnt_o    = bit_cnt_r;

endmodule

// File: tb/tb_usbh_crc_engine.sv
// Directed self-checking bench for usbh_crc_engine (DATA_W=8, CNT_W=16).
module tb_usbh_crc_engine;

   logic        clk;
   logic        rstn;
   logic        start;
   logic        mode;
   logic        abort;
   logic        valid;
   logic        ready;
   logic [7:0]  data;
   logic [3:0]  nbits;
   logic        last;
   logic        busy;
   logic        crc_valid;
   logic [15:0] crc;
   logic        residue_ok;
   logic [15:0] bit_cnt;

   int checks   = 0;
   int failures = 0;
   int pulse_cnt = 0;
   int pulse_base;

   logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

   usbh_crc_engine #(.DATA_W(8), .CNT_W(16)) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .start_i      (start),
      .mode_i       (mode),
      .abort_i      (abort),
      .valid_i      (valid),
      .ready_o      (ready),
      .data_i       (data),
      .nbits_i      (nbits),
      .last_i       (last),
      .busy_o       (busy),
      .crc_valid_o  (crc_valid),
      .crc_o        (crc),
      .residue_ok_o (residue_ok),
      .bit_cnt_o    (bit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (crc_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic md, input logic ab, input logic vl,
                        input logic [7:0] d, input logic [3:0] nb, input logic ls);
      start = st; mode = md; abort = ab; valid = vl; data = d; nbits = nb; last = ls;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   // Sends "123456789" with byte '5' xored by mask; last flag on '9' if is_last.
   task automatic send_str(input logic md, input logic [7:0] mask, input logic is_last);
      for (int i = 0; i < 9; i++) begin
         drive(i == 0, md, 1'b0, 1'b1, (i == 4) ? (msg[i] ^ mask) : msg[i], 4'd8,
               (i == 8) && is_last);
      end
   endtask

   // Bit-serial reference following the reflected algorithm, wire-order result.
   function automatic logic [15:0] ref_crc(input logic m16, input logic [63:0] bits, input int n);
      logic [15:0] r16;
      logic [4:0]  r5;
      r16 = 16'hFFFF;
      r5  = 5'h1F;
      for (int i = 0; i < n; i++) begin
         if ((r16[0] ^ bits[i]) == 1'b1) r16 = (r16 >> 1) ^ 16'hA001;
         else                            r16 = r16 >> 1;
         if ((r5[0] ^ bits[i]) == 1'b1)  r5  = (r5 >> 1) ^ 5'h14;
         else                            r5  = r5 >> 1;
      end
      return m16 ? ~r16 : {11'h000, ~r5};
   endfunction

   initial begin
      rstn = 1'b0;
      start = 1'b0; mode = 1'b0; abort = 1'b0; valid = 1'b0;
      data = 8'h00; nbits = 4'd0; last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_valid", {31'd0, crc_valid}, 32'd0);
      check("rst_crc", {16'd0, crc}, 32'd0);
      check("rst_res", {31'd0, residue_ok}, 32'd0);
      check("rst_cnt", {16'd0, bit_cnt}, 32'd0);
      rstn = 1'b1;
      idle();

      // CRC16 over "123456789"
      send_str(1'b1, 8'h00, 1'b1);
      check("c16_pulse", {31'd0, crc_valid}, 32'd1);
      check("c16_crc", {16'd0, crc}, 32'h0000B4C8);
      check("c16_cnt", {16'd0, bit_cnt}, 32'd72);
      check("c16_busy", {31'd0, busy}, 32'd0);
      idle();
      check("c16_pulse_end", {31'd0, crc_valid}, 32'd0);
      check("c16_hold", {16'd0, crc}, 32'h0000B4C8);
      valid = 1'b1;
      #1;
      check("idle_ready", {31'd0, ready}, 32'd0);
      start = 1'b1;
      #1;
      check("start_ready", {31'd0, ready}, 32'd1);
      start = 1'b0; valid = 1'b0;

      // CRC5 over the same stream
      send_str(1'b0, 8'h00, 1'b1);
      check("c5_crc", {16'd0, crc}, 32'h00000019);
      idle();

      // Checker: data plus received CRC bytes
      send_str(1'b1, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC8, 4'd8, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hB4, 4'd8, 1'b1);
      check("chk_res_ok", {31'd0, residue_ok}, 32'd1);
      check("chk_cnt", {16'd0, bit_cnt}, 32'd88);
      idle();
      send_str(1'b1, 8'h01, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC8, 4'd8, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hB4, 4'd8, 1'b1);
      check("chk_res_bad", {31'd0, residue_ok}, 32'd0);
      idle();

      // 11-bit tokens in CRC5, with a zero-width beat in the middle
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd8, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hF8, 4'd3, 1'b1);
      check("tok0_crc", {16'd0, crc}, 32'h00000002);
      check("tok0_cnt", {16'd0, bit_cnt}, 32'd11);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h3A, 4'd8, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFD, 4'd3, 1'b1);
      check("tok1_crc", {16'd0, crc}, {16'd0, ref_crc(1'b0, 64'h53A, 11)});
      idle();

      // start+valid+last single beat, then start in the DONE cycle
      pulse_base = pulse_cnt;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h31, 4'd8, 1'b1);
      check("b2b_pulse1", {31'd0, crc_valid}, 32'd1);
      check("b2b_crc1", {16'd0, crc}, {16'd0, ref_crc(1'b1, 64'h31, 8)});
      send_str(1'b1, 8'h00, 1'b1);
      check("b2b_crc2", {16'd0, crc}, 32'h0000B4C8);
      check("b2b_cnt2", {16'd0, bit_cnt}, 32'd72);
      idle();
      check("b2b_pulses", pulse_cnt - pulse_base, 32'd2);

      // abort mid-RUN
      pulse_base = pulse_cnt;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h31, 4'd8, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h32, 4'd8, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 4'd8, 1'b1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_crc", {16'd0, crc}, 32'd0);
      check("abort_cnt", {16'd0, bit_cnt}, 32'd0);
      idle();
      check("abort_nopulse", pulse_cnt - pulse_base, 32'd0);
      send_str(1'b1, 8'h00, 1'b1);
      check("abort_next_crc", {16'd0, crc}, 32'h0000B4C8);
      idle();

      // reset mid-RUN
      pulse_base = pulse_cnt;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h31, 4'd8, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h32, 4'd8, 1'b0);
      rstn = 1'b0;
      #1;
      check("rrun_busy", {31'd0, busy}, 32'd0);
      check("rrun_crc", {16'd0, crc}, 32'd0);
      check("rrun_cnt", {16'd0, bit_cnt}, 32'd0);
      idle();
      rstn = 1'b1;
      idle();
      check("rrun_nopulse", pulse_cnt - pulse_base, 32'd0);
      send_str(1'b0, 8'h00, 1'b1);
      check("rrun_next_crc", {16'd0, crc}, 32'h00000019);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
